// File: rtl/quad_position_decoder.sv
// Quadrature decoder: sync + debounce per phase, Gray-code step decode, signed position counter.
// Latency SYNC_STAGES+DEBOUNCE_CYC+1 cycles from input edge to step; no backpressure, steps are never stalled.
module quad_position_decoder #(
   parameter int CNT_W        = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter bit SATURATE     = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clear_err,
   output logic [CNT_W-1:0] position,
   output logic [1:0]       direction,
   output logic             step_pulse,
   output logic             err
);
   localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam int ARM_CYC = SYNC_STAGES + DEBOUNCE_CYC;
   localparam int ARM_W   = $clog2(ARM_CYC + 1);
   localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

   // Phase vectors are {A, B}: index 1 is A, index 0 is B.
   logic [1:0]             raw;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [DB_W-1:0]        db_cnt [2];
   logic [1:0]             synced;
   logic [1:0]             filt;
   logic [1:0]             prev;
   logic                   armed;
   logic [ARM_W-1:0]       arm_cnt;
   logic                   arm_done;
   logic [1:0]             delta;
   logic                   step_cw;
   logic                   step_ccw;
   logic                   illegal;
   logic [CNT_W-1:0]       pos_nxt;

   function automatic logic [1:0] gray_idx(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   assign raw      = {enc_a, enc_b};
   assign synced   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
   assign arm_done = (arm_cnt == ARM_W'(ARM_CYC - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '0;
            db_cnt[i] <= '0;
         end
         filt <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            if (!armed && arm_done) begin
               filt[i]   <= synced[i];
               db_cnt[i] <= '0;
            end else if (synced[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
               filt[i]   <= synced[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Index difference modulo 4: 1 = CW, 3 = CCW, 2 = both phases flipped.
   assign delta    = gray_idx(filt) - gray_idx(prev);
   assign step_cw  = armed && (delta == 2'd1);
   assign step_ccw = armed && (delta == 2'd3);
   assign illegal  = armed && (delta == 2'd2);

   always_comb begin
      pos_nxt = position;
      if (LOAD) begin
         pos_nxt = load_val;
      end else if (step_cw) begin
         if (!(SATURATE && position == POS_MAX)) pos_nxt = position + CNT_W'(1);
      end else if (step_ccw) begin
         if (!(SATURATE && position == POS_MIN)) pos_nxt = position - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         prev       <= 2'b00;
         armed      <= 1'b0;
         arm_cnt    <= '0;
         position   <= '0;
         direction  <= 2'b00;
         step_pulse <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (!armed) begin
            if (arm_done) begin
               armed <= 1'b1;
               prev  <= synced;
            end else begin
               arm_cnt <= arm_cnt + 1'b1;
            end
         end else begin
            prev <= filt;
         end
         position   <= pos_nxt;
         step_pulse <= step_cw | step_ccw;
         if (illegal) begin
            err       <= 1'b1;
            direction <= 2'b11;
         end else begin
            if (clear_err) err <= 1'b0;
            if (step_cw)                                direction <= 2'b01;
            else if (step_ccw)                          direction <= 2'b10;
            else if (clear_err && direction == 2'b11)   direction <= 2'b00;
         end
      end
   end
endmodule

// File: tb/tb_quad_position_decoder.sv
// Bench for quad_position_decoder: wrap and saturate instances share stimulus and are checked against
// an integer position model driven by the encoder's Gray sequence.
module tb_quad_position_decoder;
   localparam int LAT     = 7;   // sync 2 + debounce 4 + decode 1
   localparam int ARM_CYC = 6;

   logic       CLK;
   logic       RST;
   logic       LOAD;
   logic [7:0] load_val;
   logic       enc_a;
   logic       enc_b;
   logic       clear_err;
   logic [7:0] pos_w, pos_s;
   logic [1:0] dir_w, dir_s;
   logic       sp_w, sp_s;
   logic       err_w, err_s;

   int checks = 0;
   int errors = 0;

   logic [1:0] gc [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int enc_idx;
   int mpos_w;
   int mpos_s;

   quad_position_decoder #(.CNT_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .SATURATE(1'b0)) dut_w (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .load_val(load_val), .enc_a(enc_a), .enc_b(enc_b),
      .clear_err(clear_err), .position(pos_w), .direction(dir_w), .step_pulse(sp_w), .err(err_w));

   quad_position_decoder #(.CNT_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .SATURATE(1'b1)) dut_s (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .load_val(load_val), .enc_a(enc_a), .enc_b(enc_b),
      .clear_err(clear_err), .position(pos_s), .direction(dir_s), .step_pulse(sp_s), .err(err_s));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap8(input int v);
      return ((v % 256) + 256) % 256;
   endfunction

   function automatic int clamp8(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   task automatic check_pos(input string tag);
      check({tag, " pos_w"}, {24'd0, pos_w}, 32'(wrap8(mpos_w)));
      check({tag, " pos_s"}, {24'd0, pos_s}, 32'(wrap8(mpos_s)));
   endtask

   task automatic drive_idx();
      {enc_a, enc_b} = gc[enc_idx];
   endtask

   // Counts pulses over the arming window and a margin; none may appear.
   task automatic arm_check(input string tag);
      int np = 0;
      RST = 1'b1;
      for (int k = 0; k < ARM_CYC + 6; k++) begin
         tick();
         if (sp_w || sp_s) np++;
      end
      check({tag, " arm pulses"}, 32'(np), 32'd0);
      check_pos(tag);
      check({tag, " arm err"}, {30'd0, err_w, err_s}, 32'd0);
      check({tag, " arm dir"}, {28'd0, dir_w, dir_s}, 32'd0);
   endtask

   task automatic do_step(input bit cw, input int hold, input string tag);
      int np_w = 0, np_s = 0, at_w = -1, at_s = -1;
      enc_idx = cw ? (enc_idx + 1) % 4 : (enc_idx + 3) % 4;
      drive_idx();
      mpos_w = wrap8(mpos_w + (cw ? 1 : -1));
      mpos_s = clamp8(mpos_s + (cw ? 1 : -1));
      for (int k = 1; k <= hold; k++) begin
         tick();
         if (sp_w) begin np_w++; if (at_w < 0) at_w = k; end
         if (sp_s) begin np_s++; if (at_s < 0) at_s = k; end
      end
      check({tag, " pulses_w"}, 32'(np_w), 32'd1);
      check({tag, " pulses_s"}, 32'(np_s), 32'd1);
      check({tag, " latency_w"}, 32'(at_w), 32'(LAT));
      check({tag, " latency_s"}, 32'(at_s), 32'(LAT));
      check({tag, " dir"}, {28'd0, dir_w, dir_s}, cw ? 32'b0101 : 32'b1010);
      check_pos(tag);
   endtask

   task automatic glitch(input int phase, input int len, input string tag);
      int np = 0;
      if (phase == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
      for (int k = 0; k < len; k++) tick();
      drive_idx();
      for (int k = 0; k < 12; k++) begin
         tick();
         if (sp_w || sp_s) np++;
      end
      check({tag, " glitch pulses"}, 32'(np), 32'd0);
      check_pos(tag);
   endtask

   task automatic do_load(input logic [7:0] v);
      LOAD = 1'b1;
      load_val = v;
      tick();
      LOAD = 1'b0;
      mpos_w = wrap8(int'(v));
      mpos_s = int'($signed(v));
   endtask

   initial begin
      RST = 1'b0; LOAD = 1'b0; load_val = 8'h00; clear_err = 1'b0;
      enc_idx = 2; drive_idx();
      mpos_w = 0; mpos_s = 0;
      for (int k = 0; k < 3; k++) tick();
      check("reset pos", {16'd0, pos_w, pos_s}, 32'd0);
      check("reset dir", {28'd0, dir_w, dir_s}, 32'd0);
      check("reset sp/err", {28'd0, sp_w, sp_s, err_w, err_s}, 32'd0);

      arm_check("arm11");

      for (int i = 0; i < 4; i++) do_step(1'b1, 10, "cw4");
      for (int i = 0; i < 6; i++) do_step(1'b0, 10, "ccw6");
      check("pos after cw4/ccw6", {24'd0, pos_w}, 32'h0000_00FE);

      glitch(1, 3, "a3");

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), "rnd");
         do_step(1'($urandom_range(0, 1)), int'($urandom_range(8, 14)), "rnd");
      end

      do_load(8'h7F);
      check_pos("load7f");
      do_step(1'b1, 10, "sat_hi");
      do_load(8'h80);
      do_step(1'b0, 10, "sat_lo");
      do_load(8'h00);
      do_step(1'b0, 10, "wrap0");

      begin
         int np = 0;
         enc_idx = (enc_idx + 2) % 4;
         drive_idx();
         for (int k = 0; k < 10; k++) begin
            tick();
            if (sp_w || sp_s) np++;
         end
         check("illegal pulses", 32'(np), 32'd0);
         check("illegal err", {30'd0, err_w, err_s}, 32'b11);
         check("illegal dir", {28'd0, dir_w, dir_s}, 32'b1111);
         check_pos("illegal");
         clear_err = 1'b1;
         tick();
         clear_err = 1'b0;
         check("clear err", {30'd0, err_w, err_s}, 32'd0);
         check("clear dir", {28'd0, dir_w, dir_s}, 32'd0);
      end

      // clear_err held across an illegal transition: the illegal edge wins, the next edge clears.
      enc_idx = (enc_idx + 2) % 4;
      drive_idx();
      clear_err = 1'b1;
      for (int k = 0; k < LAT; k++) tick();
      check("overlap err", {30'd0, err_w, err_s}, 32'b11);
      check("overlap dir", {28'd0, dir_w, dir_s}, 32'b1111);
      tick();
      clear_err = 1'b0;
      check("overlap cleared err", {30'd0, err_w, err_s}, 32'd0);
      check("overlap cleared dir", {28'd0, dir_w, dir_s}, 32'd0);

      do_step(1'b1, 10, "pre_load");
      enc_idx = (enc_idx + 1) % 4;
      drive_idx();
      for (int k = 0; k < LAT - 1; k++) tick();
      LOAD = 1'b1;
      load_val = 8'h10;
      tick();
      LOAD = 1'b0;
      check("load+step sp", {30'd0, sp_w, sp_s}, 32'b11);
      check("load+step dir", {28'd0, dir_w, dir_s}, 32'b0101);
      mpos_w = 16; mpos_s = 16;
      check_pos("load+step");
      for (int k = 0; k < 4; k++) tick();
      check_pos("load+step settled");

      enc_idx = (enc_idx + 1) % 4;
      drive_idx();
      for (int k = 0; k < 3; k++) tick();
      RST = 1'b0;
      LOAD = 1'b1;
      load_val = 8'h55;
      tick();
      check("midrst pos", {16'd0, pos_w, pos_s}, 32'd0);
      check("midrst dir", {28'd0, dir_w, dir_s}, 32'd0);
      check("midrst sp/err", {28'd0, sp_w, sp_s, err_w, err_s}, 32'd0);
      tick();
      LOAD = 1'b0;
      mpos_w = 0; mpos_s = 0;
      arm_check("rearm");
      do_step(1'b1, 10, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/quad_position_decoder.md
Name: quad_position_decoder

Overview:
- Parametrised successor to the lock machine's quadrature encoder block.
- Takes raw two-phase encoder inputs (enc_a, enc_b). Synchronises and debounces each phase, decodes Gray-code quadrature steps, and keeps a signed position count of configurable width.
- Adds wrap/saturate count modes, parallel load, a one-cycle step strobe and sticky illegal-transition detection.
- Feeds the combination-compare FSM, which consumes position, direction and step_pulse.

Parameters:
- CNT_W, 8, position counter width in bits (two's complement, >=2).
- SYNC_STAGES, 2, synchroniser flops per phase input (>=2).
- DEBOUNCE_CYC, 4, consecutive stable cycles required before a phase change is accepted (>=1).
- SATURATE, 0, 0 = position wraps modulo 2^CNT_W; 1 = position clamps at signed min/max.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-low.
- LOAD  input  1  load load_val into position this cycle.
- load_val  input  CNT_W  value written to position on LOAD.
- enc_a  input  1  raw encoder phase A (asynchronous).
- enc_b  input  1  raw encoder phase B (asynchronous).
- clear_err  input  1  clears err and an error-state direction.
- position  output  CNT_W  signed step count.
- direction  output  2  00 none, 01 right/CW, 10 left/CCW, 11 illegal transition.
- step_pulse  output  1  one-cycle strobe on each accepted step.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Only CLK is used. RST is sampled on the CLK rising edge; RST=0 clears all state.
- Reset values: position=0, direction=00, step_pulse=0, err=0. Synchroniser, debounce counters, filtered and previous phase registers clear to 0. armed=0.
- Synchroniser: each phase passes through SYNC_STAGES flops.
- Debounce, per phase:
  - Counter increments while the synced value differs from the filtered value.
  - Counter clears whenever they match.
  - When the counter reaches DEBOUNCE_CYC and they still differ, the filtered value takes the synced value and the counter clears.
- Baseline after reset: the first SYNC_STAGES+DEBOUNCE_CYC cycles after RST deasserts are an arming window.
  - At the end of the window, filtered and prev are loaded directly from the synced phases and armed is set.
  - No step is counted and no error is raised.
  - The encoder resting at any of 00/01/11/10 at reset therefore produces no spurious count.
- Decode: once armed, compare registered prev {A,B} with filtered {A,B} each cycle, then prev <= filtered.
  - CW sequence 00->01->11->10->00: position+1, direction=01, step_pulse=1.
  - CCW sequence (reverse order): position-1, direction=10, step_pulse=1.
  - No change: no action. step_pulse=0; direction holds its last value.
  - Both bits changed (00<->11, 01<->10): err=1, direction=11, no count, step_pulse=0.
- Latency: an input change held stable produces step_pulse/position update exactly SYNC_STAGES+DEBOUNCE_CYC+1 rising edges after the first edge that samples the new level.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYC synced cycles is never counted.
- Arithmetic:
  - SATURATE=0: wraps, e.g. 0x7F+1 -> 0x80; 0x00-1 -> 0xFF for CNT_W=8.
  - SATURATE=1: signed clamp at 2^(CNT_W-1)-1 and -2^(CNT_W-1). A step at a limit still asserts step_pulse and updates direction.
- LOAD:
  - position <= load_val on the next edge.
  - LOAD has priority over a same-cycle step; that step is discarded, but step_pulse and direction still update.
  - LOAD does not touch err or the decode state.
- clear_err:
  - Clears err, and clears direction to 00 if it was 11.
  - A same-cycle illegal transition wins (err stays 1).
- Reset mid-operation: all state clears regardless of LOAD or steps in progress, and the arming window restarts.

Test Plan:
- Reset then arm with enc_a=1, enc_b=1 held: after the arming window, position=0, err=0, direction=00, no step_pulse.
- Four clean CW quadrature steps, each phase held 10 cycles (defaults): four single-cycle step_pulses, each 7 cycles after the sampled change; position=4; direction=01. Then 6 CCW steps: position=-2 (0xFE), direction=10.
- 3-cycle glitch on enc_a: no step_pulse, position unchanged.
- Wrap/saturate, starting from LOAD load_val=0x7F followed by one CW step:
  - SATURATE=0: position=0x80.
  - SATURATE=1: position=0x7F, step_pulse=1.
  - LOAD 0x80 then one CCW step with SATURATE=1: position stays 0x80.
- Drive enc_a and enc_b to toggle together from 00 to 11: err=1, direction=11, position unchanged. Pulse clear_err: err=0, direction=00.
- Assert LOAD with load_val=0x10 on the same cycle as a decoded CW step: position=0x10, step_pulse=1. Assert RST=0 mid-sequence: all outputs return to reset values on the next edge.
